// File: rtl/fir_ctrl_pkg.sv
// Shared constants for the FIR MAC/RAM scheduler: bus widths, default tap count
// and the scheduler state encoding.
package fir_ctrl_pkg;

    localparam int P_ADDR_W   = 6;
    localparam int P_DATA_W   = 16;
    localparam int P_NTAP_DEF = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UPDATE = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_READ   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // Address of the last coefficient for a filter of ntap taps.
    function automatic logic [P_ADDR_W-1:0] last_tap_addr(input int ntap);
        return P_ADDR_W'(ntap - 1);
    endfunction

endpackage

// File: rtl/tap_addr_counter.sv
// Coefficient address counter: cleared before a read burst, advances once per
// read cycle and saturates at the last tap so it can never wrap inside a burst.
module tap_addr_counter
    import fir_ctrl_pkg::*;
#(
    parameter int P_NTAP = P_NTAP_DEF
)
(
    input  logic                iClk_12M,
    input  logic                iRst,
    input  logic                clr_i,
    input  logic                inc_i,
    output logic [P_ADDR_W-1:0] cnt_o,
    output logic                last_o
);

    localparam logic [P_ADDR_W-1:0] LP_LAST = last_tap_addr(P_NTAP);
    localparam logic [P_ADDR_W-1:0] LP_ZERO = {P_ADDR_W{1'b0}};
    localparam logic [P_ADDR_W-1:0] LP_ONE  = {{(P_ADDR_W-1){1'b0}}, 1'b1};

    logic [P_ADDR_W-1:0] cnt_q;
    logic [P_ADDR_W-1:0] cnt_d;

    // Next count: clear has priority, increment stops at the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = LP_ZERO;
        end else if (inc_i && (cnt_q != LP_LAST)) begin
            cnt_d = cnt_q + LP_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            cnt_q <= LP_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == LP_LAST);

endmodule

// File: rtl/mac_ram_scheduler.sv
// FIR control scheduler: arbitrates the coefficient SpSram between host updates
// and per-sample tap reads, and sequences the delay-line shift and MAC strobes.
module mac_ram_scheduler
    import fir_ctrl_pkg::*;
#(
    parameter int P_NTAP   = P_NTAP_DEF,
    parameter int P_RD_LAT = 1
)
(
    input  logic                       iClk_12M,
    input  logic                       iRst,
    input  logic                       iCoeffiUpdateFlag,
    input  logic                       iHostCsn,
    input  logic                       iHostWrn,
    input  logic [P_ADDR_W-1:0]        iHostAddr,
    input  logic signed [P_DATA_W-1:0] iHostWrDt,
    output logic                       oHostBusy,
    input  logic                       iSmplValid,
    output logic                       oSmplReady,
    output logic                       oCsnRam,
    output logic                       oWrnRam,
    output logic [P_ADDR_W-1:0]        oAddrRam,
    output logic signed [P_DATA_W-1:0] oWrDtRam,
    output logic                       oShiftEn,
    output logic [P_ADDR_W-1:0]        oTapSel,
    output logic                       oEnMac,
    output logic                       oClrAcc,
    output logic                       oOutValid
);

    localparam logic [P_ADDR_W-1:0] LP_ADDR_ZERO = {P_ADDR_W{1'b0}};
    localparam logic [P_DATA_W-1:0] LP_DATA_ZERO = {P_DATA_W{1'b0}};

    logic [2:0]          state_q;
    logic [2:0]          state_d;
    logic [P_ADDR_W-1:0] tap_cnt_s;
    logic                tap_last_s;
    logic                rd_s;

    logic [P_RD_LAT-1:0] en_pipe_q;
    logic [P_ADDR_W-1:0] tap_pipe_q [P_RD_LAT];

    assign rd_s = (state_q == S_READ);

    tap_addr_counter #(
        .P_NTAP (P_NTAP)
    ) u_tap_addr_counter (
        .iClk_12M (iClk_12M),
        .iRst     (iRst),
        .clr_i    (state_q == S_SHIFT),
        .inc_i    (rd_s),
        .cnt_o    (tap_cnt_s),
        .last_o   (tap_last_s)
    );

    // Next-state logic; an update request only takes effect from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (iCoeffiUpdateFlag) begin
                    state_d = S_UPDATE;
                end else if (iSmplValid) begin
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_UPDATE: begin
                if (!iCoeffiUpdateFlag) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_UPDATE;
                end
            end
            S_SHIFT: state_d = S_READ;
            S_READ: begin
                if (tap_last_s) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Align MAC enable and tap index with coefficient data returning from RAM.
    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            en_pipe_q <= {P_RD_LAT{1'b0}};
            for (int i = 0; i < P_RD_LAT; i++) begin
                tap_pipe_q[i] <= LP_ADDR_ZERO;
            end
        end else begin
            en_pipe_q[0]  <= rd_s;
            tap_pipe_q[0] <= tap_cnt_s;
            for (int i = 1; i < P_RD_LAT; i++) begin
                en_pipe_q[i]  <= en_pipe_q[i-1];
                tap_pipe_q[i] <= tap_pipe_q[i-1];
            end
        end
    end

    // RAM port ownership: host passthrough in UPDATE, tap reads in READ, idle otherwise.
    always_comb begin
        oCsnRam  = 1'b1;
        oWrnRam  = 1'b1;
        oAddrRam = LP_ADDR_ZERO;
        oWrDtRam = LP_DATA_ZERO;
        case (state_q)
            S_UPDATE: begin
                oCsnRam  = iHostCsn;
                oWrnRam  = iHostWrn;
                oAddrRam = iHostAddr;
                oWrDtRam = iHostWrDt;
            end
            S_READ: begin
                oCsnRam  = 1'b0;
                oWrnRam  = 1'b1;
                oAddrRam = tap_cnt_s;
                oWrDtRam = LP_DATA_ZERO;
            end
            default: begin
                oCsnRam  = 1'b1;
                oWrnRam  = 1'b1;
                oAddrRam = LP_ADDR_ZERO;
                oWrDtRam = LP_DATA_ZERO;
            end
        endcase
    end

    assign oEnMac     = en_pipe_q[P_RD_LAT-1];
    assign oTapSel    = tap_pipe_q[P_RD_LAT-1];
    assign oClrAcc    = oEnMac && (oTapSel == LP_ADDR_ZERO);
    assign oShiftEn   = (state_q == S_SHIFT);
    assign oOutValid  = (state_q == S_DONE);
    assign oHostBusy  = (state_q != S_UPDATE);
    assign oSmplReady = !iRst && (state_q == S_IDLE) && !iCoeffiUpdateFlag;

endmodule

// File: tb/tb_mac_ram_scheduler.sv
// Scoreboard bench for mac_ram_scheduler: a 16-tap and a 64-tap instance share
// stimulus; expected shift/read/MAC/valid events are queued per cycle tick.
module tb_mac_ram_scheduler;

    logic               clk;
    logic               rst;
    logic               flag;
    logic               hcsn;
    logic               hwrn;
    logic [5:0]         haddr;
    logic signed [15:0] hdata;
    logic               valid;

    logic        busy16, ready16, csn16, wrn16, sh16, en16, clr16, ov16;
    logic [5:0]  addr16, tap16;
    logic signed [15:0] wd16;
    logic        busy64, ready64, csn64, wrn64, sh64, en64, clr64, ov64;
    logic [5:0]  addr64, tap64;
    logic signed [15:0] wd64;

    mac_ram_scheduler #(.P_NTAP(16), .P_RD_LAT(1)) dut16 (
        .iClk_12M(clk), .iRst(rst), .iCoeffiUpdateFlag(flag),
        .iHostCsn(hcsn), .iHostWrn(hwrn), .iHostAddr(haddr), .iHostWrDt(hdata),
        .oHostBusy(busy16), .iSmplValid(valid), .oSmplReady(ready16),
        .oCsnRam(csn16), .oWrnRam(wrn16), .oAddrRam(addr16), .oWrDtRam(wd16),
        .oShiftEn(sh16), .oTapSel(tap16), .oEnMac(en16), .oClrAcc(clr16),
        .oOutValid(ov16));

    mac_ram_scheduler #(.P_NTAP(64), .P_RD_LAT(1)) dut64 (
        .iClk_12M(clk), .iRst(rst), .iCoeffiUpdateFlag(flag),
        .iHostCsn(hcsn), .iHostWrn(hwrn), .iHostAddr(haddr), .iHostWrDt(hdata),
        .oHostBusy(busy64), .iSmplValid(valid), .oSmplReady(ready64),
        .oCsnRam(csn64), .oWrnRam(wrn64), .oAddrRam(addr64), .oWrDtRam(wd64),
        .oShiftEn(sh64), .oTapSel(tap64), .oEnMac(en64), .oClrAcc(clr64),
        .oOutValid(ov64));

    logic sel;
    logic mon_en;
    logic upd_win;
    int   cyc;
    int   n_checks;
    int   n_fail;

    typedef struct {
        int t;
        int v;
    } ev_t;

    int  sh_q[$];
    int  ov_q[$];
    ev_t rd_q[$];
    ev_t mac_q[$];

    logic busy_s, ready_s, csn_s, wrn_s, sh_s, en_s, clr_s, ov_s;
    logic [5:0] addr_s, tap_s;
    logic [15:0] wd_s;

    assign busy_s  = sel ? busy64  : busy16;
    assign ready_s = sel ? ready64 : ready16;
    assign csn_s   = sel ? csn64   : csn16;
    assign wrn_s   = sel ? wrn64   : wrn16;
    assign sh_s    = sel ? sh64    : sh16;
    assign en_s    = sel ? en64    : en16;
    assign clr_s   = sel ? clr64   : clr16;
    assign ov_s    = sel ? ov64    : ov16;
    assign addr_s  = sel ? addr64  : addr16;
    assign tap_s   = sel ? tap64   : tap16;
    assign wd_s    = sel ? wd64    : wd16;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at tick %0d", cyc);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (tick %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    // Sample accepted at tick t: shift at t, reads t+1.., MAC one cycle later, result at t+n+2.
    task automatic push_seq(input int t, input int n);
        sh_q.push_back(t);
        for (int k = 0; k < n; k++) begin
            rd_q.push_back('{t: t + 1 + k, v: k});
            mac_q.push_back('{t: t + 2 + k, v: k});
        end
        ov_q.push_back(t + n + 2);
    endtask

    task automatic flush_after(input int t);
        while (sh_q.size() > 0 && sh_q[$] > t) void'(sh_q.pop_back());
        while (ov_q.size() > 0 && ov_q[$] > t) void'(ov_q.pop_back());
        while (rd_q.size() > 0 && rd_q[$].t > t) void'(rd_q.pop_back());
        while (mac_q.size() > 0 && mac_q[$].t > t) void'(mac_q.pop_back());
    endtask

    task automatic start_sample(input int n, output int t);
        t = cyc + 1;
        valid = 1'b1;
        push_seq(t, n);
        tick();
        valid = 1'b0;
    endtask

    task automatic check_empty();
        check_eq("sb_shift_left", sh_q.size(), 0);
        check_eq("sb_read_left", rd_q.size(), 0);
        check_eq("sb_mac_left", mac_q.size(), 0);
        check_eq("sb_valid_left", ov_q.size(), 0);
    endtask

    logic exp_b;
    ev_t  cur;

    // Per-cycle monitor: every cycle without a queued event must show idle strobes.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_b = (sh_q.size() > 0) && (sh_q[0] == cyc);
            if (exp_b) void'(sh_q.pop_front());
            check_eq("shift_en", sh_s, exp_b);

            exp_b = (ov_q.size() > 0) && (ov_q[0] == cyc);
            if (exp_b) void'(ov_q.pop_front());
            check_eq("out_valid", ov_s, exp_b);

            if (rd_q.size() > 0 && rd_q[0].t == cyc) begin
                cur = rd_q.pop_front();
                check_eq("rd_csn", csn_s, 0);
                check_eq("rd_wrn", wrn_s, 1);
                check_eq("rd_addr", addr_s, cur.v);
                check_eq("rd_wrdt", wd_s, 0);
            end else if (!upd_win) begin
                check_eq("idle_csn", csn_s, 1);
                check_eq("idle_wrn", wrn_s, 1);
                check_eq("idle_addr", addr_s, 0);
                check_eq("idle_wrdt", wd_s, 0);
            end

            if (mac_q.size() > 0 && mac_q[0].t == cyc) begin
                cur = mac_q.pop_front();
                check_eq("mac_en", en_s, 1);
                check_eq("mac_tap", tap_s, cur.v);
                check_eq("mac_clr", clr_s, (cur.v == 0) ? 1 : 0);
            end else begin
                check_eq("mac_en_idle", en_s, 0);
                check_eq("mac_clr_idle", clr_s, 0);
            end
        end
    end

    int t0;
    int t1;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        sel      = 1'b0;
        mon_en   = 1'b0;
        upd_win  = 1'b0;
        rst      = 1'b1;
        flag     = 1'b0;
        valid    = 1'b0;
        hcsn     = 1'b1;
        hwrn     = 1'b1;
        haddr    = 6'd0;
        hdata    = 16'sd0;

        // Reset state, still inside reset.
        tick(); tick(); tick();
        check_eq("rst_ready", ready_s, 0);
        check_eq("rst_busy", busy_s, 1);
        check_eq("rst_csn", csn_s, 1);
        check_eq("rst_tap", tap_s, 0);
        check_eq("rst_valid", ov_s, 0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", ready_s, 1);
        mon_en = 1'b1;

        // Single sample accepted at edge 10.
        wait_until(9);
        start_sample(16, t0);
        check_eq("accept_tick", t0, 10);
        wait_until(t0 + 5);
        check_eq("ready_in_read", ready_s, 0);
        wait_until(t0 + 16 + 3);
        check_eq("ready_back_idle", ready_s, 1);
        check_empty();

        // Update and sample requested together: update wins, host write forwarded.
        hcsn  = 1'b0;
        hwrn  = 1'b0;
        haddr = 6'd5;
        hdata = 16'sh7FFF;
        flag  = 1'b1;
        valid = 1'b1;
        #1;
        check_eq("both_ready", ready_s, 0);
        check_eq("both_busy_idle", busy_s, 1);
        tick();
        upd_win = 1'b1;
        #1;
        check_eq("upd_busy", busy_s, 0);
        check_eq("upd_csn", csn_s, 0);
        check_eq("upd_wrn", wrn_s, 0);
        check_eq("upd_addr", addr_s, 5);
        check_eq("upd_wrdt", wd_s, 32'h7FFF);
        check_eq("upd_ready", ready_s, 0);
        hcsn = 1'b1;
        hwrn = 1'b1;
        #1;
        check_eq("upd_csn_release", csn_s, 1);
        tick();
        flag  = 1'b0;
        valid = 1'b0;
        tick();
        upd_win = 1'b0;
        check_eq("upd_exit_busy", busy_s, 1);

        // Update raised mid-READ: sequence completes, host strobes ignored until UPDATE.
        hcsn  = 1'b0;
        hwrn  = 1'b0;
        haddr = 6'd5;
        hdata = 16'sh1234;
        start_sample(16, t0);
        wait_until(t0 + 8);
        flag = 1'b1;
        wait_until(t0 + 16 + 3);
        check_eq("late_upd_busy_idle", busy_s, 1);
        check_eq("late_upd_ready", ready_s, 0);
        tick();
        upd_win = 1'b1;
        #1;
        check_eq("late_upd_busy", busy_s, 0);
        check_eq("late_upd_csn", csn_s, 0);
        check_eq("late_upd_addr", addr_s, 5);
        check_eq("late_upd_wrdt", wd_s, 32'h1234);
        flag = 1'b0;
        hcsn = 1'b1;
        hwrn = 1'b1;
        tick();
        upd_win = 1'b0;
        check_eq("late_upd_exit_busy", busy_s, 1);
        check_empty();

        // Reset at READ address 9 drops the sequence; a fresh sample then completes.
        start_sample(16, t0);
        wait_until(t0 + 10);
        rst = 1'b1;
        flush_after(cyc);
        #1;
        check_eq("midrst_ready", ready_s, 0);
        tick();
        rst = 1'b0;
        check_eq("midrst_shift", sh_s, 0);
        check_eq("midrst_csn", csn_s, 1);
        check_eq("midrst_addr", addr_s, 0);
        check_eq("midrst_en", en_s, 0);
        check_eq("midrst_tap", tap_s, 0);
        check_eq("midrst_valid", ov_s, 0);
        check_eq("midrst_busy", busy_s, 1);
        tick();
        start_sample(16, t0);
        wait_until(t0 + 16 + 3);
        check_empty();

        // 64 taps, back-to-back samples.
        mon_en = 1'b0;
        rst    = 1'b1;
        tick(); tick();
        rst    = 1'b0;
        sel    = 1'b1;
        flush_after(-1);
        #1;
        check_eq("sel64_ready", ready_s, 1);
        mon_en = 1'b1;
        t0 = cyc + 1;
        valid = 1'b1;
        push_seq(t0, 64);
        t1 = t0 + 64 + 4;
        push_seq(t1, 64);
        wait_until(t0 + 64 + 2);
        check_eq("b2b_ready_done", ready_s, 0);
        wait_until(t1 - 1);
        check_eq("b2b_ready_after_done", ready_s, 1);
        tick();
        valid = 1'b0;
        wait_until(t1 + 64 + 3);
        check_empty();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_ram_scheduler.md
MAC_RAM_SCHEDULER -- requirements
Module: mac_ram_scheduler

Interface
REQ-001 SHALL provide parameter P_NTAP, default 16, number of filter taps (legal 2..64).
REQ-002 SHALL provide parameter P_RD_LAT, default 1, coefficient SpSram read latency in cycles (fixed 1).
REQ-003 SHALL have port iClk_12M  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port iRst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port iCoeffiUpdateFlag  in  1  host request for a coefficient-update window.
REQ-006 SHALL have ports iHostCsn, iHostWrn  in  1 each  host RAM chip-select and write strobes, active-low.
REQ-007 SHALL have port iHostAddr  in  6  host coefficient address.
REQ-008 SHALL have port iHostWrDt  in  16  signed host coefficient data.
REQ-009 SHALL have port oHostBusy  out  1  high while the host does not own the RAM.
REQ-010 SHALL have ports iSmplValid  in  1 and oSmplReady  out  1  new-sample handshake.
REQ-011 SHALL have ports oCsnRam, oWrnRam  out  1 each, oAddrRam  out  6, oWrDtRam  out  16 signed  SpSram port.
REQ-012 SHALL have port oShiftEn  out  1  one-cycle delay-line shift pulse.
REQ-013 SHALL have port oTapSel  out  6  tap index aligned with RAM read data.
REQ-014 SHALL have ports oEnMac, oClrAcc, oOutValid  out  1 each  MAC enable, accumulator load-not-add, result strobe.

Function
REQ-015 SHALL implement states IDLE, UPDATE, SHIFT, READ, DRAIN, DONE.
REQ-016 IDLE SHALL go to UPDATE if iCoeffiUpdateFlag=1; else to SHIFT if iSmplValid=1; else stay. When both are high, update wins.
REQ-017 oSmplReady SHALL be 1 only in IDLE with iCoeffiUpdateFlag=0. A sample is accepted when iSmplValid && oSmplReady.
REQ-018 UPDATE SHALL pass iHostCsn/iHostWrn/iHostAddr/iHostWrDt combinationally to the RAM port, and SHALL return to IDLE when iCoeffiUpdateFlag=0.
REQ-019 oHostBusy SHALL be 0 only in UPDATE. Outside UPDATE, host strobes SHALL be ignored and the RAM port SHALL be driven by the scheduler.
REQ-020 SHIFT SHALL last 1 cycle with oShiftEn=1, clear the tap counter to 0, and go to READ.
REQ-021 READ SHALL drive oCsnRam=0, oWrnRam=1, oAddrRam=counter, incrementing each cycle. After counter==P_NTAP-1 it SHALL go to DRAIN.
REQ-022 The counter SHALL compare against P_NTAP-1 and never rely on 6-bit wrap; P_NTAP=64 SHALL end at address 63.
REQ-023 DRAIN SHALL last 1 cycle and go to DONE. DONE SHALL last 1 cycle with oOutValid=1 and go to IDLE.
REQ-024 oEnMac and oTapSel SHALL equal the READ-state indication and counter delayed by P_RD_LAT cycles.
REQ-025 oClrAcc SHALL be 1 exactly in the oEnMac cycle with oTapSel=0.
REQ-026 Latency: a sample accepted at edge T SHALL give oShiftEn at T+1, reads T+2..T+1+P_NTAP, and oOutValid at T+3+P_NTAP.
REQ-027 iCoeffiUpdateFlag rising during SHIFT..DONE SHALL NOT abort the sequence. UPDATE SHALL be entered from the following IDLE.
REQ-028 Outside READ/UPDATE, the RAM port SHALL be oCsnRam=1, oWrnRam=1, oAddrRam=0, oWrDtRam=0. oWrDtRam SHALL be 0 in READ.

Reset
REQ-029 While iRst=1, the next edge SHALL force: IDLE, counter 0, oCsnRam=1, oWrnRam=1, oAddrRam=0, oWrDtRam=0, oShiftEn/oEnMac/oClrAcc/oOutValid=0, oTapSel=0, oHostBusy=1.
REQ-030 oSmplReady SHALL be 0 while iRst=1.
REQ-031 Reset mid-sequence SHALL drop all pulses on the next edge. The partial result SHALL never produce oOutValid, and delayed oEnMac/oTapSel pipeline registers SHALL also clear.

Structure
REQ-032 Shared package fir_ctrl_pkg SHALL hold the state encoding, P_ADDR_W=6, P_DATA_W=16 and the default P_NTAP.
REQ-033 The address counter with terminal-count compare SHALL be sub-module tap_addr_counter. The FSM and latency pipeline stay in mac_ram_scheduler.

Verification
REQ-034 P_NTAP=16, one iSmplValid pulse at edge 10 -> oShiftEn@11; addr 0..15 @12..27; oEnMac@13..28 with oClrAcc@13; oOutValid@29 only.
REQ-035 iCoeffiUpdateFlag and iSmplValid both high in IDLE -> UPDATE entered, oSmplReady=0, no oShiftEn. Host write addr 5 data 0x7FFF appears on the RAM port the same cycle.
REQ-036 iCoeffiUpdateFlag raised at READ addr 7 -> reads continue to 15, oOutValid still asserted, then UPDATE. Host strobes before that are not forwarded.
REQ-037 iRst pulsed at READ addr 9 -> next cycle all outputs at reset values, no oOutValid; a new sample afterwards completes normally.
REQ-038 P_NTAP=64, back-to-back iSmplValid -> addr 0..63 with no wrap to 0 inside READ; the second sample is accepted the cycle after DONE.
